// File: rtl/multiplier_seq_param.sv
// multiplier_seq_param
// Sequential shift-and-add multiplier with the datapath and controller in a
// single block. The two operands share one bus: A is taken on the start
// cycle and B on the cycle after it. Signed operands are turned into
// magnitudes, multiplied unsigned, and the sign is put back at the end.
// The loop stops as soon as the remaining multiplier bits are all zero.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset (0 = reset)
//   start    request, sampled in IDLE only
//   sgn      1 = signed two's complement, 0 = unsigned; sampled with A
//   data_in  operand bus (A on the start cycle, B on the next cycle)
//   product  2*WIDTH-bit result, held from DONE until the next result
//   busy     high in LOAD_B, CALC and DONE
//   done     one-cycle pulse in DONE
module multiplier_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     data_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic                 r_sgn;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_absA;
    logic [WIDTH-1:0]     w_absB;
    logic [2*WIDTH-1:0]   w_accNext;
    logic [2*WIDTH-1:0]   w_accNeg;
    logic [WIDTH-1:0]     w_mplierNext;

    // Magnitudes are plain W-bit unsigned values, so the most negative
    // operand -2^(W-1) maps onto 2^(W-1) without needing an extra bit.
    assign w_absA = (r_sgn && r_a[WIDTH-1]) ? (~r_a + ONE_W) : r_a;
    assign w_absB = (r_sgn && data_in[WIDTH-1]) ? (~data_in + ONE_W) : data_in;

    // One shift-and-add step; the product register is loaded from the
    // post-add value so the final step needs no extra cycle.
    assign w_accNext    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_accNeg     = ~w_accNext + ONE_P;
    assign w_mplierNext = r_mplier >> 1;

    // Controller and datapath share one sequential block; busy/done are
    // registered and set on the edge that enters the matching state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_sgn     <= 1'b0;
            r_neg     <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= data_in;
                        r_sgn   <= sgn;
                        r_busy  <= 1'b1;
                        r_state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    r_mcand  <= {{WIDTH{1'b0}}, w_absA};
                    r_mplier <= w_absB;
                    r_acc    <= '0;
                    r_neg    <= r_sgn & (r_a[WIDTH-1] ^ data_in[WIDTH-1]);
                    r_state  <= CALC;
                end
                CALC: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplierNext;
                    // Early exit: nothing left to add once the shifted
                    // multiplier is zero, which also covers B = 0.
                    if (w_mplierNext == '0) begin
                        r_product <= r_neg ? w_accNeg : w_accNext;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_multiplier_seq_param.sv
// tb_multiplier_seq_param
// Directed checks of an 8-bit instance (latency, early exit, signed corner
// cases, start handling, asynchronous reset abort) and a randomised run of
// a 16-bit instance against an arithmetic reference model.
module tb_multiplier_seq_param;

    logic        clk;
    logic        rst_n;

    logic        start8;
    logic        sgn8;
    logic [7:0]  din8;
    logic [15:0] prod8;
    logic        busy8;
    logic        done8;

    logic        start16;
    logic        sgn16;
    logic [15:0] din16;
    logic [31:0] prod16;
    logic        busy16;
    logic        done16;

    int errorCount;
    int checkCount;

    multiplier_seq_param #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start8),
        .sgn     (sgn8),
        .data_in (din8),
        .product (prod8),
        .busy    (busy8),
        .done    (done8)
    );

    multiplier_seq_param #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .reset   (rst_n),
        .start   (start16),
        .sgn     (sgn16),
        .data_in (din16),
        .product (prod16),
        .busy    (busy16),
        .done    (done16)
    );

    // Free-running 10-unit clock shared by both instances
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one 8-bit operation; expCalc is the expected number of CALC cycles
    task automatic applyStimulus(input string tag, input logic [7:0] a,
                                 input logic [7:0] b, input logic s,
                                 input logic [15:0] expProd, input int expCalc);
        int   edges;
        logic seen;
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = s;
        din8   = a;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        din8   = b;
        checkOutput({tag, "_busyLoadB"}, 32'(busy8), 32'd1);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done8) seen = 1'b1;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'(expCalc + 1));
        checkOutput({tag, "_product"}, 32'(prod8), 32'(expProd));
        @(posedge clk);
        #1;
        checkOutput({tag, "_donePulse"}, 32'(done8), 32'd0);
        checkOutput({tag, "_busyIdle"}, 32'(busy8), 32'd0);
        checkOutput({tag, "_hold"}, 32'(prod8), 32'(expProd));
    endtask

    // Reference number of CALC cycles: max(1, MSB index of |B| + 1)
    function automatic int calcLen16(input logic [15:0] b, input logic s);
        logic [15:0] m;
        int          n;
        m = (s && b[15]) ? (~b + 16'd1) : b;
        n = 1;
        for (int i = 0; i < 16; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    // Reference product computed with native 64-bit arithmetic
    function automatic logic [31:0] refProd16(input logic [15:0] a,
                                              input logic [15:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({48'd0, a}) * longint'({48'd0, b});
        return p[31:0];
    endfunction

    // Runs one 16-bit operation and checks product and CALC length
    task automatic applyStimulus16(input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        int   edges;
        logic seen;
        @(negedge clk);
        start16 = 1'b1;
        sgn16   = s;
        din16   = a;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        din16   = b;
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done16) seen = 1'b1;
        end
        checkOutput("w16_calcLen", 32'(edges - 1), 32'(calcLen16(b, s)));
        checkOutput("w16_product", prod16, refProd16(a, b, s));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          edges;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;

        errorCount = 0;
        checkCount = 0;
        rst_n   = 1'b0;
        start8  = 1'b0;
        sgn8    = 1'b0;
        din8    = '0;
        start16 = 1'b0;
        sgn16   = 1'b0;
        din16   = '0;

        // Reset state
        #12;
        checkOutput("rst_product", 32'(prod8), 32'd0);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_product16", prod16, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned and signed directed vectors
        applyStimulus("u8x9",      8'd8,   8'd9,   1'b0, 16'd72,   4);
        applyStimulus("u255x255",  8'd255, 8'd255, 1'b0, 16'hFE01, 8);
        applyStimulus("u200x0",    8'd200, 8'd0,   1'b0, 16'd0,    1);
        applyStimulus("sM3x5",     8'hFD,  8'd5,   1'b1, 16'hFFF1, 3);
        applyStimulus("sM128xM128",8'h80,  8'h80,  1'b1, 16'h4000, 8);
        applyStimulus("s127xM128", 8'd127, 8'h80,  1'b1, 16'hC080, 8);
        applyStimulus("sM1x1",     8'hFF,  8'd1,   1'b1, 16'hFFFF, 1);

        // start held high, with start/data_in noise during CALC
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = 1'b0;
        din8   = 8'd3;
        @(posedge clk);
        #1;
        din8 = 8'd7;
        @(posedge clk);
        #1;
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            din8   = 8'($urandom);
            start8 = 1'($urandom);
            @(posedge clk);
            #1;
            edges++;
            if (done8) seen = 1'b1;
        end
        checkOutput("hold_latency", 32'(edges), 32'd4);
        checkOutput("hold_product", 32'(prod8), 32'd21);
        start8 = 1'b1;
        din8   = 8'd3;
        @(posedge clk);
        #1;
        checkOutput("hold_noRestartInDone", 32'(busy8), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hold_restartAfterDone", 32'(busy8), 32'd1);
        start8 = 1'b0;
        din8   = 8'd7;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done8) seen = 1'b1;
        end
        checkOutput("hold_secondDone", 32'(seen), 32'd1);
        checkOutput("hold_secondProduct", 32'(prod8), 32'd21);
        @(posedge clk);
        #1;

        // Asynchronous reset in the third CALC cycle
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = 1'b0;
        din8   = 8'd17;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        din8   = 8'd255;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_product", 32'(prod8), 32'd0);
        checkOutput("abort_busy", 32'(busy8), 32'd0);
        checkOutput("abort_done", 32'(done8), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done8) seen = 1'b1;
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done8) seen = 1'b1;
        end
        checkOutput("abort_noDonePulse", 32'(seen), 32'd0);
        applyStimulus("afterReset", 8'd6, 8'd7, 1'b0, 16'd42, 3);

        // 16-bit corner cases, then random operands
        applyStimulus16(16'h8000, 16'h8000, 1'b1);
        applyStimulus16(16'hFFFF, 16'hFFFF, 1'b0);
        applyStimulus16(16'h7FFF, 16'h8000, 1'b1);
        applyStimulus16(16'h1234, 16'h0000, 1'b1);
        for (int k = 0; k < 1000; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            rs = 1'($urandom_range(0, 1));
            applyStimulus16(ra, rb, rs);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
